cameralink_pattern_gen: RTL and testbench

CAMERALINK_PATTERN_GEN -- requirements
Module: cameralink_pattern_gen

---
 rtl/cameralink_pattern_gen.sv | 203 ++++++++++++++++++++
 tb/tb_cameralink_pattern_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cameralink_pattern_gen.sv
// -----------------------------------------------------------------------------
// cameralink_pattern_gen
// Camera Link style test-pattern source. It produces a repeating frame of
// VBLANK idle cycles, then SIZEY lines. Each line is HBLANK blank cycles
// followed by SIZEX/TAPS active beats. Every output comes from a register.
//
// Ports
//   CLK        in   1            sole clock, rising edge
//   Reset_n    in   1            asynchronous active-low reset
//   Enable     in   1            run request (sampled in IDLE and at end of frame)
//   Mode       in   2            0 diag ramp, 1 horiz ramp, 2 checker, 3 frame stamp
//   AB_DATA    out  TAPS*DATA_W  tap k at [k*DATA_W +: DATA_W], pixel x_cnt+k
//   LVAL       out  1            line valid
//   FVAL       out  1            frame valid
//   DVAL       out  1            data valid (mirrors LVAL)
//   x_cnt      out  16           pixel index of tap 0 on the current beat
//   y_cnt      out  16           line index within the frame
//   frame_cnt  out  16           completed-frame count (wraps)
//   Frame_done out  1            one-cycle pulse after the last active beat
// -----------------------------------------------------------------------------
module cameralink_pattern_gen #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 2,
  parameter int SIZEX  = 640,
  parameter int SIZEY  = 512,
  parameter int HBLANK = 10,
  parameter int VBLANK = 50
) (
  input  logic                     CLK,
  input  logic                     Reset_n,
  input  logic                     Enable,
  input  logic [1:0]               Mode,
  output logic [TAPS*DATA_W-1:0]   AB_DATA,
  output logic                     LVAL,
  output logic                     FVAL,
  output logic                     DVAL,
  output logic [15:0]              x_cnt,
  output logic [15:0]              y_cnt,
  output logic [15:0]              frame_cnt,
  output logic                     Frame_done
);

  localparam int BLANK_MAX = (VBLANK > HBLANK) ? VBLANK : HBLANK;
  localparam int CNT_W     = $clog2(BLANK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK_ST = 2'd1,
    HBLANK_ST = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  state_t                   state_r,  state_s;
  logic [CNT_W-1:0]         cnt_r,    cnt_s;
  logic [15:0]              x_r,      x_s;
  logic [15:0]              y_r,      y_s;
  logic [15:0]              fc_r,     fc_s;
  logic [1:0]               mode_r,   mode_s;
  logic                     done_s;
  logic [TAPS*DATA_W-1:0]   pix_s;

  logic [TAPS*DATA_W-1:0]   ab_data_r;
  logic                     lval_r;
  logic                     fval_r;
  logic                     done_r;

  // Pixel values for all taps of one beat; pixel x of tap k is x+k.
  function automatic logic [TAPS*DATA_W-1:0] make_pixels(
    input logic [1:0]  mode,
    input logic [15:0] x,
    input logic [15:0] y,
    input logic [15:0] fc
  );
    logic [TAPS*DATA_W-1:0] data;
    logic [31:0]            px;
    logic [31:0]            sum;
    data = '0;
    for (int k = 0; k < TAPS; k++) begin
      px  = 32'(x) + 32'(k);
      sum = px + 32'(y);
      case (mode)
        2'd0:    data[k*DATA_W +: DATA_W] = DATA_W'(sum);
        2'd1:    data[k*DATA_W +: DATA_W] = DATA_W'(px);
        2'd2:    data[k*DATA_W +: DATA_W] = (px[3] ^ y[3]) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
        2'd3:    data[k*DATA_W +: DATA_W] = DATA_W'(fc);
        default: data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      endcase
    end
    return data;
  endfunction

  // Next-state, counter and mode-latch logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    x_s     = x_r;
    y_s     = y_r;
    fc_s    = fc_r;
    mode_s  = mode_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Enable) begin
          state_s = VBLANK_ST;
          cnt_s   = '0;
          mode_s  = Mode;
        end else begin
          state_s = IDLE;
        end
      end
      VBLANK_ST: begin
        if (cnt_r == CNT_W'(VBLANK - 1)) begin
          state_s = HBLANK_ST;
          cnt_s   = '0;
          y_s     = 16'd0;
          mode_s  = Mode;   // pattern is fixed for the whole upcoming frame
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      HBLANK_ST: begin
        if (cnt_r == CNT_W'(HBLANK - 1)) begin
          state_s = ACTIVE;
          cnt_s   = '0;
          x_s     = 16'd0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (x_r == 16'(SIZEX - TAPS)) begin
          x_s   = 16'd0;
          cnt_s = '0;
          if (y_r == 16'(SIZEY - 1)) begin
            // Enable only matters here, so a frame is never cut short.
            done_s  = 1'b1;
            fc_s    = fc_r + 16'd1;
            y_s     = 16'd0;
            state_s = Enable ? VBLANK_ST : IDLE;
          end else begin
            y_s     = y_r + 16'd1;
            state_s = HBLANK_ST;
          end
        end else begin
          x_s = x_r + 16'(TAPS);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        x_s     = 16'd0;
        y_s     = 16'd0;
      end
    endcase
  end

  // Beat data for the state being entered; blank outside ACTIVE.
  always_comb begin
    pix_s = '0;
    if (state_s == ACTIVE) begin
      pix_s = make_pixels(mode_s, x_s, y_s, fc_s);
    end else begin
      pix_s = '0;
    end
  end

  // State, counters and registered outputs; outputs track the state entered.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      x_r       <= 16'd0;
      y_r       <= 16'd0;
      fc_r      <= 16'd0;
      mode_r    <= 2'd0;
      ab_data_r <= '0;
      lval_r    <= 1'b0;
      fval_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      x_r       <= x_s;
      y_r       <= y_s;
      fc_r      <= fc_s;
      mode_r    <= mode_s;
      ab_data_r <= pix_s;
      lval_r    <= (state_s == ACTIVE);
      fval_r    <= (state_s == ACTIVE) || (state_s == HBLANK_ST);
      done_r    <= done_s;
    end
  end

  assign AB_DATA    = ab_data_r;
  assign LVAL       = lval_r;
  assign DVAL       = lval_r;
  assign FVAL       = fval_r;
  assign x_cnt      = x_r;
  assign y_cnt      = y_r;
  assign frame_cnt  = fc_r;
  assign Frame_done = done_r;

endmodule

// File: tb/tb_cameralink_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_cameralink_pattern_gen
// Directed bench. Instance u_dut is the small frame (8x4, 2 taps, HBLANK 3,
// VBLANK 5). u_chk is a 32x16 frame that exercises the checkerboard pattern.
// The cycle index "rel" counts rising edges after Enable is raised.
// -----------------------------------------------------------------------------
module tb_cameralink_pattern_gen;

  logic        CLK;
  logic        Reset_n;
  logic        Enable;
  logic [1:0]  Mode;
  logic [31:0] AB_DATA;
  logic        LVAL, FVAL, DVAL, Frame_done;
  logic [15:0] x_cnt, y_cnt, frame_cnt;

  logic        en2;
  logic [1:0]  mode2;
  logic [31:0] ab2;
  logic        lval2, fval2, dval2, done2;
  logic [15:0] x2, y2, fc2;

  int n_cmp = 0;
  int n_err = 0;
  int rel   = 0;
  int hits;

  cameralink_pattern_gen #(.DATA_W(16), .TAPS(2), .SIZEX(8), .SIZEY(4),
                           .HBLANK(3), .VBLANK(5)) u_dut (
    .CLK(CLK), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode),
    .AB_DATA(AB_DATA), .LVAL(LVAL), .FVAL(FVAL), .DVAL(DVAL),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt), .Frame_done(Frame_done)
  );

  cameralink_pattern_gen #(.DATA_W(16), .TAPS(2), .SIZEX(32), .SIZEY(16),
                           .HBLANK(3), .VBLANK(5)) u_chk (
    .CLK(CLK), .Reset_n(Reset_n), .Enable(en2), .Mode(mode2),
    .AB_DATA(ab2), .LVAL(lval2), .FVAL(fval2), .DVAL(dval2),
    .x_cnt(x2), .y_cnt(y2), .frame_cnt(fc2), .Frame_done(done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    rel++;
  endtask

  task automatic step_to(input int k);
    while (rel < k) tick();
  endtask

  initial begin
    Reset_n = 1'b0; Enable = 1'b0; Mode = 2'd0; en2 = 1'b0; mode2 = 2'd0;
    tick(); tick();
    chk("rst_ab",   AB_DATA, 32'h0);
    chk("rst_lval", LVAL, 1'b0);
    chk("rst_fval", FVAL, 1'b0);
    chk("rst_dval", DVAL, 1'b0);
    chk("rst_x",    x_cnt, 16'd0);
    chk("rst_y",    y_cnt, 16'd0);
    chk("rst_fc",   frame_cnt, 16'd0);
    chk("rst_done", Frame_done, 1'b0);
    Reset_n = 1'b1;
    tick(); tick(); tick();
    chk("idle_fval", FVAL, 1'b0);

    // Frame 1 diagonal ramp, frame 2 horizontal, frame 3 diagonal, then stop.
    Enable = 1'b1; Mode = 2'd0; rel = 0;
    step_to(1);  chk("vb_fval1", FVAL, 1'b0);
    step_to(5);  chk("vb_fval5", FVAL, 1'b0);
    chk("vb_lval5", LVAL, 1'b0);
    step_to(6);  chk("hb_fval", FVAL, 1'b1);
    chk("hb_lval", LVAL, 1'b0);
    chk("hb_y", y_cnt, 16'd0);
    step_to(8);  chk("hb_lval8", LVAL, 1'b0);
    step_to(9);  chk("act_lval", LVAL, 1'b1);
    chk("act_dval", DVAL, 1'b1);
    chk("act_x0", x_cnt, 16'd0);
    chk("act_ab_l0b0", AB_DATA, 32'h0001_0000);
    step_to(12); chk("act_x6", x_cnt, 16'd6);
    chk("act_ab_l0b3", AB_DATA, 32'h0007_0006);
    step_to(13); chk("gap_lval", LVAL, 1'b0);
    chk("gap_ab", AB_DATA, 32'h0);
    chk("gap_fval", FVAL, 1'b1);
    chk("gap_y1", y_cnt, 16'd1);
    step_to(18); chk("ab_l1b2", AB_DATA, 32'h0006_0005);
    chk("x_l1b2", x_cnt, 16'd4);
    step_to(33); chk("ab_l3b3", AB_DATA, 32'h000A_0009);
    chk("y_l3", y_cnt, 16'd3);
    chk("done_pre1", Frame_done, 1'b0);
    step_to(34); chk("done1", Frame_done, 1'b1);
    chk("fc1", frame_cnt, 16'd1);
    chk("fval_end1", FVAL, 1'b0);
    step_to(35); chk("done1_off", Frame_done, 1'b0);
    Mode = 2'd1;
    step_to(38); chk("vb2_fval", FVAL, 1'b0);
    step_to(39); chk("hb2_fval", FVAL, 1'b1);
    step_to(43); chk("hr_l0b1", AB_DATA, 32'h0003_0002);
    step_to(50); Mode = 2'd0;
    step_to(56); chk("hr_l2b0", AB_DATA, 32'h0001_0000);
    chk("hr_y2", y_cnt, 16'd2);
    step_to(63); chk("hr_l3b0", AB_DATA, 32'h0001_0000);
    step_to(66); chk("done_pre2", Frame_done, 1'b0);
    step_to(67); chk("done2", Frame_done, 1'b1);
    chk("fc2", frame_cnt, 16'd2);
    step_to(82); chk("dr_l1b0", AB_DATA, 32'h0002_0001);
    chk("dr_y1", y_cnt, 16'd1);
    step_to(83); Enable = 1'b0;
    step_to(96); chk("noend_lval", LVAL, 1'b1);
    chk("noend_y3", y_cnt, 16'd3);
    chk("noend_fval", FVAL, 1'b1);
    step_to(99); chk("dr_l3b3", AB_DATA, 32'h000A_0009);
    step_to(100); chk("done3", Frame_done, 1'b1);
    chk("fval_end3", FVAL, 1'b0);
    chk("fc3", frame_cnt, 16'd3);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (FVAL || LVAL) hits++;
    end
    chk("idle_quiet", hits, 0);

    // Asynchronous reset in the middle of an active line.
    Enable = 1'b1; Mode = 2'd1; rel = 0;
    step_to(10); chk("pre_rst_lval", LVAL, 1'b1);
    chk("pre_rst_x", x_cnt, 16'd2);
    #2 Reset_n = 1'b0; Enable = 1'b0;
    #1;
    chk("ar_ab",   AB_DATA, 32'h0);
    chk("ar_lval", LVAL, 1'b0);
    chk("ar_fval", FVAL, 1'b0);
    chk("ar_dval", DVAL, 1'b0);
    chk("ar_x",    x_cnt, 16'd0);
    chk("ar_fc",   frame_cnt, 16'd0);
    tick(); tick();
    Reset_n = 1'b1;
    tick();
    chk("ar_idle", FVAL, 1'b0);

    // Frame stamp over three frames, full VBLANK after reset.
    Enable = 1'b1; Mode = 2'd3; rel = 0;
    step_to(5);  chk("fs_vb5", FVAL, 1'b0);
    step_to(6);  chk("fs_hb6", FVAL, 1'b1);
    chk("fs_fc0", frame_cnt, 16'd0);
    step_to(9);  chk("fs_lval", LVAL, 1'b1);
    chk("fs_ab0", AB_DATA, 32'h0);
    step_to(34); chk("fs_done1", Frame_done, 1'b1);
    step_to(42); chk("fs_ab1", AB_DATA, 32'h0001_0001);
    step_to(66); chk("fs_pre2", Frame_done, 1'b0);
    step_to(67); chk("fs_done2", Frame_done, 1'b1);
    step_to(68); Enable = 1'b0;
    step_to(75); chk("fs_ab2", AB_DATA, 32'h0002_0002);
    step_to(99); chk("fs_ab2_last", AB_DATA, 32'h0002_0002);
    step_to(100); chk("fs_done3", Frame_done, 1'b1);
    chk("fs_fc3", frame_cnt, 16'd3);
    step_to(101); chk("fs_idle", FVAL, 1'b0);

    // Checkerboard on the wide instance.
    en2 = 1'b1; mode2 = 2'd2; rel = 0;
    step_to(9);   chk("cb_lval", lval2, 1'b1);
    chk("cb_l0_x0", ab2, 32'h0);
    step_to(12);  chk("cb_l0_x6", ab2, 32'h0);
    step_to(13);  chk("cb_l0_x8", ab2, 32'hFFFF_FFFF);
    chk("cb_x8", x2, 16'd8);
    step_to(16);  chk("cb_l0_x14", ab2, 32'hFFFF_FFFF);
    step_to(17);  chk("cb_l0_x16", ab2, 32'h0);
    chk("cb_x16", x2, 16'd16);
    step_to(161); chk("cb_y8", y2, 16'd8);
    chk("cb_l8_x0", ab2, 32'hFFFF_FFFF);
    en2 = 1'b0;
    step_to(165); chk("cb_l8_x8", ab2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
